// File: rtl/branch_resolve_bht.sv
// Branch resolver with a bimodal table of 2-bit counters for fetch-stage direction
// prediction, plus saturating branch and mispredict statistics.
module branch_resolve_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [3:0]       info_branch,
  input  logic [XLEN-1:0]  reg1,
  input  logic [XLEN-1:0]  reg2,
  input  logic             ex_pred_taken,
  output logic             branch_signal,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IW = $clog2(BHT_ENTRIES);

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_kind_e;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IW-1:0] pred_idx, ex_idx;
  logic          eq, sl, slu;
  logic          is_cond, is_jump;
  logic [1:0]    ctr_cur, ctr_d;

  // Only the word-aligned index bits of each PC address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[XLEN-1:IW+2], ex_pc[1:0], ex_pc[XLEN-1:IW+2]};

  assign pred_idx = pred_pc[2 +: IW];
  assign ex_idx   = ex_pc[2 +: IW];

  assign eq  = (reg1 == reg2);
  assign sl  = ($signed(reg1) < $signed(reg2));
  assign slu = (reg1 < reg2);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    branch_signal = 1'b0;
    is_cond       = 1'b0;
    is_jump       = 1'b0;
    case (info_branch)
      BR_BEQ:  begin is_cond = 1'b1; branch_signal = eq;   end
      BR_BNE:  begin is_cond = 1'b1; branch_signal = !eq;  end
      BR_BLT:  begin is_cond = 1'b1; branch_signal = sl;   end
      BR_BGE:  begin is_cond = 1'b1; branch_signal = !sl;  end
      BR_BLTU: begin is_cond = 1'b1; branch_signal = slu;  end
      BR_BGEU: begin is_cond = 1'b1; branch_signal = !slu; end
      BR_JAL, BR_JALR: begin is_jump = 1'b1; branch_signal = 1'b1; end
      default: ;
    endcase
  end

  assign mispredict = ex_valid & ((is_cond & (branch_signal != ex_pred_taken)) |
                                  (is_jump & !ex_pred_taken));

  // Read reflects the pre-edge table; a same-cycle update is not bypassed.
  assign pred_taken = bht_q[pred_idx][1];

  always_comb begin
    ctr_cur = bht_q[ex_idx];
    ctr_d   = ctr_cur;
    if (branch_signal) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (ex_valid && (is_cond || is_jump) && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (mispredict && (mispredict_cnt_q != '1))
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
  end

  // NOTE: the table is a flop array, not a RAM macro, so it can and must be reset
  // to weakly-not-taken in one cycle; sequential state uses non-blocking assigns
  // so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (ex_valid && is_cond) bht_q[ex_idx] <= ctr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: compare decode, counter training,
// aliasing, jumps, statistics saturation and mid-stream reset.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  info_branch;
  logic [31:0] reg1, reg2;
  logic        ex_pred_taken;
  logic        branch_signal, mispredict;
  logic [3:0]  branch_cnt, mispredict_cnt;

  int total = 0;
  int bad   = 0;

  branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .info_branch(info_branch),
    .reg1(reg1), .reg2(reg2), .ex_pred_taken(ex_pred_taken),
    .branch_signal(branch_signal), .mispredict(mispredict),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] code,
                       input logic [31:0] r1, input logic [31:0] r2, input logic ept);
    ex_valid = v; ex_pc = pc; info_branch = code; reg1 = r1; reg2 = r2; ex_pred_taken = ept;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pred_pc = 32'h40;
    drive(1'b1, 32'h40, 4'd1, 32'h5, 32'h5, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0);
    for (int a = 0; a < 64; a++) begin
      pred_pc = 32'(a * 4);
      #1;
      total++;
      if (pred_taken !== 1'b0) begin
        $display("FAIL reset_pred pc=%h got=%b want=0", pred_pc, pred_taken); bad++;
      end
    end
    total++;
    if (branch_cnt !== 4'd0) begin $display("FAIL reset_bcnt got=%0d want=0", branch_cnt); bad++; end
    total++;
    if (mispredict_cnt !== 4'd0) begin $display("FAIL reset_mcnt got=%0d want=0", mispredict_cnt); bad++; end
  endtask

  task automatic test_compare();
    logic [3:0] codes [13];
    logic [31:0] r1s [13];
    logic [31:0] r2s [13];
    logic       want [13];
    codes = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd7, 4'd8, 4'd0, 4'd9, 4'd15, 4'd3, 4'd5};
    r1s   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h1234,
              32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h80000000, 32'h7FFFFFFF};
    r2s   = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1234, 32'h1234,
              32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h7FFFFFFF, 32'h80000000};
    want  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 32'h0, codes[i], r1s[i], r2s[i], 1'b0);
      total++;
      if (branch_signal !== want[i]) begin
        $display("FAIL cmp code=%0d r1=%h r2=%h got=%b want=%b",
                 codes[i], r1s[i], r2s[i], branch_signal, want[i]); bad++;
      end
    end
    drive(1'b0, 32'h40, 4'd2, 32'h1, 32'h2, 1'b0);
    total++;
    if (mispredict !== 1'b0) begin $display("FAIL invalid_mp got=%b want=0", mispredict); bad++; end
    tick();
    total++;
    if (branch_cnt !== 4'd0) begin $display("FAIL invalid_cnt got=%0d want=0", branch_cnt); bad++; end
    pred_pc = 32'h40; #1;
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL invalid_tbl got=%b want=0", pred_taken); bad++; end
  endtask

  task automatic test_training();
    logic exp_pred [3];
    logic exp_mp [3];
    exp_pred = '{1'b0, 1'b1, 1'b1};
    exp_mp   = '{1'b1, 1'b0, 1'b0};
    pred_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40, 4'd1, 32'h7, 32'h7, exp_pred[i]);
      total++;
      if (pred_taken !== exp_pred[i]) begin
        $display("FAIL train_pred step=%0d got=%b want=%b", i, pred_taken, exp_pred[i]); bad++;
      end
      total++;
      if (mispredict !== exp_mp[i]) begin
        $display("FAIL train_mp step=%0d got=%b want=%b", i, mispredict, exp_mp[i]); bad++;
      end
      tick();
    end
    ex_valid = 1'b0; #1;
    total++;
    if (pred_taken !== 1'b1) begin $display("FAIL train_sat got=%b want=1", pred_taken); bad++; end
    total++;
    if (mispredict_cnt !== 4'd1) begin $display("FAIL train_mcnt got=%0d want=1", mispredict_cnt); bad++; end
    total++;
    if (branch_cnt !== 4'd3) begin $display("FAIL train_bcnt got=%0d want=3", branch_cnt); bad++; end
  endtask

  task automatic test_alias();
    pred_pc = 32'h140; #1;
    total++;
    if (pred_taken !== 1'b1) begin $display("FAIL alias_140 got=%b want=1", pred_taken); bad++; end
    pred_pc = 32'h44; #1;
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL alias_44 got=%b want=0", pred_taken); bad++; end
    pred_pc = 32'h43; #1;
    total++;
    if (pred_taken !== 1'b1) begin $display("FAIL alias_low_bits got=%b want=1", pred_taken); bad++; end
  endtask

  task automatic test_back_to_back();
    // Four not-taken then two taken at 0x40: 11->10->01->00->00->01->10.
    logic       taken [6];
    logic       exp_pred [6];
    logic       exp_after [6];
    taken     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_pred  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_after = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pred_pc = 32'h40;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h40, 4'd1, 32'h9, taken[i] ? 32'h9 : 32'h8, exp_pred[i]);
      total++;
      if (mispredict !== (taken[i] != exp_pred[i])) begin
        $display("FAIL b2b_mp step=%0d got=%b want=%b", i, mispredict, taken[i] != exp_pred[i]); bad++;
      end
      tick();
      total++;
      if (pred_taken !== exp_after[i]) begin
        $display("FAIL b2b_pred step=%0d got=%b want=%b", i, pred_taken, exp_after[i]); bad++;
      end
    end
    ex_valid = 1'b0; #1;
    total++;
    if (branch_cnt !== 4'd9) begin $display("FAIL b2b_bcnt got=%0d want=9", branch_cnt); bad++; end
    total++;
    if (mispredict_cnt !== 4'd5) begin $display("FAIL b2b_mcnt got=%0d want=5", mispredict_cnt); bad++; end
  endtask

  task automatic test_jump();
    pred_pc = 32'h80;
    drive(1'b1, 32'h80, 4'd7, 32'h1, 32'h2, 1'b0);
    total++;
    if (branch_signal !== 1'b1) begin $display("FAIL jal_bs got=%b want=1", branch_signal); bad++; end
    total++;
    if (mispredict !== 1'b1) begin $display("FAIL jal_mp got=%b want=1", mispredict); bad++; end
    tick();
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL jal_tbl got=%b want=0", pred_taken); bad++; end
    drive(1'b1, 32'h80, 4'd8, 32'h1, 32'h2, 1'b1);
    total++;
    if (mispredict !== 1'b0) begin $display("FAIL jalr_ok_mp got=%b want=0", mispredict); bad++; end
    tick();
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL jalr_tbl got=%b want=0", pred_taken); bad++; end
    drive(1'b1, 32'h80, 4'd0, 32'h1, 32'h1, 1'b1);
    total++;
    if (mispredict !== 1'b0) begin $display("FAIL none_mp got=%b want=0", mispredict); bad++; end
    tick();
    ex_valid = 1'b0; #1;
    total++;
    if (branch_cnt !== 4'd11) begin $display("FAIL jump_bcnt got=%0d want=11", branch_cnt); bad++; end
    total++;
    if (mispredict_cnt !== 4'd6) begin $display("FAIL jump_mcnt got=%0d want=6", mispredict_cnt); bad++; end
  endtask

  task automatic test_reset_midstream();
    // 0x40 holds 10 here; reset edge carries a taken update that must be dropped.
    rst = 1'b1; pred_pc = 32'h40;
    drive(1'b1, 32'h40, 4'd1, 32'h3, 32'h3, 1'b0);
    total++;
    if (pred_taken !== 1'b1) begin $display("FAIL rst_comb_pred got=%b want=1", pred_taken); bad++; end
    total++;
    if (mispredict !== 1'b1) begin $display("FAIL rst_comb_mp got=%b want=1", mispredict); bad++; end
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0);
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL rst_mid_pred got=%b want=0", pred_taken); bad++; end
    total++;
    if (branch_cnt !== 4'd0) begin $display("FAIL rst_mid_bcnt got=%0d want=0", branch_cnt); bad++; end
    total++;
    if (mispredict_cnt !== 4'd0) begin $display("FAIL rst_mid_mcnt got=%0d want=0", mispredict_cnt); bad++; end
  endtask

  task automatic test_stat_saturation();
    // One taken BEQ at 0x40 (01 -> 10 proves reset left 01), then JALs, all mispredicted.
    drive(1'b1, 32'h40, 4'd1, 32'h3, 32'h3, 1'b0);
    tick();
    total++;
    if (pred_taken !== 1'b1) begin $display("FAIL sat_tbl_01 got=%b want=1", pred_taken); bad++; end
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'h100, 4'd7, 32'h0, 32'h0, 1'b0);
      tick();
    end
    ex_valid = 1'b0; #1;
    total++;
    if (branch_cnt !== 4'd15) begin $display("FAIL sat_bcnt16 got=%0d want=15", branch_cnt); bad++; end
    total++;
    if (mispredict_cnt !== 4'd15) begin $display("FAIL sat_mcnt16 got=%0d want=15", mispredict_cnt); bad++; end
    drive(1'b1, 32'h100, 4'd8, 32'h0, 32'h0, 1'b0);
    tick();
    ex_valid = 1'b0; #1;
    total++;
    if (branch_cnt !== 4'd15) begin $display("FAIL sat_bcnt_hold got=%0d want=15", branch_cnt); bad++; end
    total++;
    if (mispredict_cnt !== 4'd15) begin $display("FAIL sat_mcnt_hold got=%0d want=15", mispredict_cnt); bad++; end
  endtask

  initial begin
    rst = 1'b1; pred_pc = '0;
    ex_valid = 1'b0; ex_pc = '0; info_branch = '0; reg1 = '0; reg2 = '0; ex_pred_taken = 1'b0;
    tick();
    test_reset();
    test_compare();
    test_training();
    test_alias();
    test_back_to_back();
    test_jump();
    test_reset_midstream();
    test_stat_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
